funct_generator_multich: RTL and testbench

// Multi-channel LUT waveform generator. Successor of the single-channel generator; adds:
//   - per-channel phase-accumulator frequency tuning
//   - per-channel waveform select and amplitude
//   - round-robin channel interleave
//   - FIFO backpressure stall, and drain on stop

---
 rtl/funct_generator_multich_if.sv | 32 +++
 rtl/funct_generator_multich.sv | 157 +++++++++++++++
 tb/tb_funct_generator_multich.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/funct_generator_multich_if.sv
// Handshake/config bundle between a controller and the multi-channel LUT waveform generator.
// The slave side is the generator; the master side drives configuration and FIFO status.
interface funct_generator_multich_if #(
   parameter int DATA_WIDTH = 16,
   parameter int INT_BITS   = 8,
   parameter int PHASE_W    = 10,
   parameter int NUM_CH     = 2
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                         en_low_i;
   logic                         enh_conf_i;
   logic [CH_W-1:0]              cfg_ch_i;
   logic signed [INT_BITS-1:0]   amp_i;
   logic [1:0]                   sel_i;
   logic [PHASE_W-1:0]           step_i;
   logic                         full_i;
   logic                         wr_en_o;
   logic signed [DATA_WIDTH-1:0] data_o;
   logic [CH_W-1:0]              ch_o;
   logic [1:0]                   state_o;

   modport master (
      output en_low_i, enh_conf_i, cfg_ch_i, amp_i, sel_i, step_i, full_i,
      input  wr_en_o, data_o, ch_o, state_o
   );

   modport slave (
      input  en_low_i, enh_conf_i, cfg_ch_i, amp_i, sel_i, step_i, full_i,
      output wr_en_o, data_o, ch_o, state_o
   );
endinterface

// File: rtl/funct_generator_multich.sv
// Multi-channel LUT waveform generator: per-channel phase accumulators, round-robin issue,
// two-stage waveform/scale pipeline feeding a FIFO write port, with full_i backpressure.
//
// state | meaning
// IDLE  | waiting; config request has priority over run
// CONFI | one channel's amp/sel/step latched per cycle, its phase cleared
// GEN   | round-robin sample issue while FIFO not full
// DRAIN | no new issue; flush both pipeline stages, then IDLE
module funct_generator_multich #(
   parameter int DATA_WIDTH = 16,
   parameter int INT_BITS   = 8,
   parameter int LUT_ADDR   = 6,
   parameter int PHASE_W    = 10,
   parameter int NUM_CH     = 2
) (
   input logic                     clk,
   input logic                     rst,
   funct_generator_multich_if.slave bus
);
   localparam int L    = 1 << LUT_ADDR;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW   = DATA_WIDTH + INT_BITS;

   localparam logic signed [DATA_WIDTH-1:0] FS     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] NFS    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] NEG_FS = -FS;
   localparam logic signed [PW-1:0]         FS_X   = {{INT_BITS{1'b0}}, FS};
   localparam logic signed [PW-1:0]         NFS_X  = {{INT_BITS{1'b1}}, NFS};
   localparam logic [LUT_ADDR-1:0]          QTR    = LUT_ADDR'(L / 4);
   localparam logic [CH_W-1:0]              LAST   = CH_W'(NUM_CH - 1);
   localparam real                          FS_R   = real'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam real                          PI     = 3.14159265358979323846;

   typedef enum logic [1:0] {IDLE = 2'd0, CONFI = 2'd1, GEN = 2'd2, DRAIN = 2'd3} state_t;

   state_t state, state_nxt;

   logic signed [INT_BITS-1:0]   amp   [NUM_CH];
   logic [1:0]                   sel   [NUM_CH];
   logic [PHASE_W-1:0]           step  [NUM_CH];
   logic [PHASE_W-1:0]           phase [NUM_CH];
   logic [CH_W-1:0]              ptr;

   logic                         issue;
   logic [LUT_ADDR-1:0]          a;
   logic [LUT_ADDR-1:0]          cidx;
   logic signed [DATA_WIDTH-1:0] ramp;
   logic signed [DATA_WIDTH-1:0] wave;

   logic                         s1_valid, s2_valid;
   logic [CH_W-1:0]              s1_ch, s2_ch;
   logic signed [DATA_WIDTH-1:0] s1_wave, s2_data;
   logic signed [INT_BITS-1:0]   s1_amp;
   logic signed [PW-1:0]         prod, shifted;
   logic signed [DATA_WIDTH-1:0] scaled;

   // Sine table, rounded to nearest at elaboration.
   logic signed [DATA_WIDTH-1:0] lut [L];
   for (genvar k = 0; k < L; k++) begin : g_lut
      localparam real RV = FS_R * $sin(2.0 * PI * k / L);
      localparam int  IV = (RV >= 0.0) ? $rtoi(RV + 0.5) : -$rtoi(0.5 - RV);
      assign lut[k] = DATA_WIDTH'(IV);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.enh_conf_i)                    state_nxt = CONFI;
                  else if (!bus.en_low_i)                state_nxt = GEN;
         CONFI:   if (!bus.enh_conf_i)                   state_nxt = IDLE;
         GEN:     if (bus.enh_conf_i || bus.en_low_i)    state_nxt = DRAIN;
         DRAIN:   if (!s1_valid && !s2_valid)            state_nxt = IDLE;
         default:                                        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue       = (state == GEN) && !bus.full_i;
      bus.wr_en_o = s2_valid && !bus.full_i;
      bus.data_o  = s2_data;
      bus.ch_o    = s2_ch;
      bus.state_o = state;
   end

   assign a    = phase[ptr][PHASE_W-1 -: LUT_ADDR];
   assign cidx = a + QTR;
   assign ramp = {a[LUT_ADDR-2:0], {(DATA_WIDTH-LUT_ADDR+1){1'b0}}};

   always_comb begin
      wave = '0;
      case (sel[ptr])
         2'd0:    wave = lut[a];
         2'd1:    wave = lut[cidx];
         2'd2:    wave = a[LUT_ADDR-1] ? (FS - ramp) : (ramp + NFS);
         default: wave = a[LUT_ADDR-1] ? NEG_FS : FS;
      endcase
   end

   always_comb begin
      prod    = s1_wave * s1_amp;
      shifted = prod >>> (INT_BITS - 2);
      if (shifted > FS_X)       scaled = FS;
      else if (shifted < NFS_X) scaled = NFS;
      else                      scaled = shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            amp[i]   <= '0;
            sel[i]   <= '0;
            step[i]  <= '0;
            phase[i] <= '0;
         end
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_wave  <= '0;
         s1_amp   <= '0;
         s2_valid <= 1'b0;
         s2_ch    <= '0;
         s2_data  <= '0;
      end else begin
         if (state == CONFI && int'(bus.cfg_ch_i) < NUM_CH) begin
            amp[bus.cfg_ch_i]   <= bus.amp_i;
            sel[bus.cfg_ch_i]   <= bus.sel_i;
            step[bus.cfg_ch_i]  <= bus.step_i;
            phase[bus.cfg_ch_i] <= '0;
         end
         // Pointer is held at 0 outside GEN so every run starts on channel 0.
         if (state != GEN) begin
            ptr <= '0;
         end else if (issue) begin
            phase[ptr] <= phase[ptr] + step[ptr];
            ptr        <= (ptr == LAST) ? '0 : ptr + 1'b1;
         end
         if (!bus.full_i) begin
            s1_valid <= issue;
            if (issue) begin
               s1_wave <= wave;
               s1_ch   <= ptr;
               s1_amp  <= amp[ptr];
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= scaled;
               s2_ch   <= s1_ch;
            end
         end
      end
   end
endmodule

// File: tb/tb_funct_generator_multich.sv
// Scoreboard bench for the multi-channel waveform generator: bursts of expected samples are
// queued from a spec-level model and popped by a monitor on every FIFO write.
module tb_funct_generator_multich;
   localparam int  DW  = 16;
   localparam int  IB  = 8;
   localparam int  LA  = 6;
   localparam int  PW  = 10;
   localparam int  NCH = 3;
   localparam int  L   = 1 << LA;
   localparam int  FS  = (1 << (DW - 1)) - 1;
   localparam real PI  = 3.14159265358979323846;

   typedef struct {
      int ch;
      int data;
      int nph;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   funct_generator_multich_if #(.DATA_WIDTH(DW), .INT_BITS(IB), .PHASE_W(PW), .NUM_CH(NCH)) bus ();

   funct_generator_multich #(
      .DATA_WIDTH(DW), .INT_BITS(IB), .LUT_ADDR(LA), .PHASE_W(PW), .NUM_CH(NCH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   checks = 0;
   int   failures = 0;
   int   wr_count = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   m_amp[NCH], m_sel[NCH], m_step[NCH], mdl_phase[NCH];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   function automatic int model_sample(input int s, input int amp, input int ph);
      int  a, w, p, frac;
      real ang;
      a    = ph / (1 << (PW - LA));
      ang  = 2.0 * PI * a / L;
      frac = (a % (L / 2)) * (1 << (DW - LA + 1));
      case (s)
         0:       w = rnd(FS * $sin(ang));
         1:       w = rnd(FS * $cos(ang));
         2:       w = (a < L / 2) ? frac - (1 << (DW - 1)) : FS - frac;
         default: w = (a < L / 2) ? FS : -FS;
      endcase
      p = (w * amp) >>> (IB - 2);
      if (p > FS)      p = FS;
      if (p < -FS - 1) p = -FS - 1;
      return p;
   endfunction

   always @(negedge clk) begin
      if (rst && bus.wr_en_o) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=ch%0d/%0d required=no write", bus.ch_o, bus.data_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sample_ch", int'(bus.ch_o), mon_e.ch);
            chk("sample_data", int'(bus.data_o), mon_e.data);
            mdl_phase[mon_e.ch] = mon_e.nph;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_amp[c] = 0; m_sel[c] = 0; m_step[c] = 0; mdl_phase[c] = 0;
      end
   endtask

   task automatic build_expected(input int n);
      int ph[NCH];
      for (int c = 0; c < NCH; c++) ph[c] = mdl_phase[c];
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         int   c;
         exp_t e;
         c      = i % NCH;
         e.ch   = c;
         e.data = model_sample(m_sel[c], m_amp[c], ph[c]);
         ph[c]  = (ph[c] + m_step[c]) % (1 << PW);
         e.nph  = ph[c];
         exp_q.push_back(e);
      end
   endtask

   task automatic enter_confi(input int with_run);
      bus.en_low_i   = (with_run != 0) ? 1'b0 : 1'b1;
      bus.enh_conf_i = 1'b1;
      tick();
      chk("confi_entry", int'(bus.state_o), 1);
   endtask

   task automatic cfg_one(input int c, input int s, input int amp, input int st, input bit last);
      bus.cfg_ch_i   = 2'(c);
      bus.sel_i      = 2'(s);
      bus.amp_i      = 8'(amp);
      bus.step_i     = 10'(st);
      bus.enh_conf_i = !last;
      if (last) bus.en_low_i = 1'b1;
      tick();
      if (c < NCH) begin
         m_sel[c] = s; m_amp[c] = amp; m_step[c] = st; mdl_phase[c] = 0;
      end
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.state_o == 2'd0) break;
      end
      chk(name, int'(bus.state_o), 0);
      @(posedge clk);
      #2;
   endtask

   task automatic stall5();
      int d, c;
      bus.full_i = 1'b1;
      d = int'(bus.data_o);
      c = int'(bus.ch_o);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_wr_en", int'(bus.wr_en_o), 0);
         chk("stall_data", int'(bus.data_o), d);
         chk("stall_ch", int'(bus.ch_o), c);
         @(posedge clk);
         #2;
      end
      bus.full_i = 1'b0;
   endtask

   task automatic run_burst(input int ncyc, input int do_stall);
      int base;
      build_expected(ncyc + 8);
      bus.full_i   = 1'b0;
      bus.en_low_i = 1'b0;
      tick();
      chk("gen_entry", int'(bus.state_o), 2);
      base = wr_count;
      tick();
      tick();
      chk("no_early_write", wr_count - base, 0);
      @(negedge clk);
      chk("first_write_latency", int'(bus.wr_en_o), 1);
      @(posedge clk);
      #2;
      for (int i = 0; i < ncyc; i++) begin
         if (do_stall != 0 && i == ncyc / 2) begin
            stall5();
         end else begin
            bus.full_i = ($urandom_range(0, 3) == 0);
            tick();
         end
      end
      bus.full_i = 1'b0;
      repeat (3) tick();
      bus.en_low_i = 1'b1;
      tick();
      chk("drain_entry", int'(bus.state_o), 3);
      base = wr_count;
      wait_idle("drain_to_idle");
      chk("drain_writes", wr_count - base, 2);
      exp_q.delete();
   endtask

   initial begin
      bus.en_low_i   = 1'b1;
      bus.enh_conf_i = 1'b0;
      bus.cfg_ch_i   = '0;
      bus.amp_i      = '0;
      bus.sel_i      = '0;
      bus.step_i     = '0;
      bus.full_i     = 1'b0;
      model_reset();
      #12;
      chk("reset_wr_en", int'(bus.wr_en_o), 0);
      chk("reset_data", int'(bus.data_o), 0);
      chk("reset_ch", int'(bus.ch_o), 0);
      chk("reset_state", int'(bus.state_o), 0);
      tick();
      rst = 1'b1;
      tick();
      chk("idle_hold", int'(bus.state_o), 0);

      // sine/square/triangle mix with a mid-run stall
      enter_confi(1);
      cfg_one(0, 0, 64, 16, 1'b0);
      cfg_one(1, 3, 64, 5, 1'b0);
      cfg_one(2, 2, 32, 100, 1'b1);
      chk("confi_exit", int'(bus.state_o), 0);
      run_burst(80, 1);

      // saturation, zero gain, most-negative gain and an out-of-range channel write
      enter_confi(0);
      cfg_one(0, 3, 127, 33, 1'b0);
      cfg_one(3, 0, 5, 1, 1'b0);
      cfg_one(1, 3, 0, 7, 1'b0);
      cfg_one(2, 3, -128, 64, 1'b1);
      run_burst(60, 0);

      for (int r = 0; r < 4; r++) begin
         int nc;
         nc = $urandom_range(1, 4);
         enter_confi(r % 2);
         for (int k = 0; k < nc; k++)
            cfg_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255) - 128,
                    $urandom_range(0, 1023), k == nc - 1);
         run_burst($urandom_range(30, 120), r % 2);
      end

      // asynchronous reset in the middle of a run
      enter_confi(0);
      cfg_one(0, 3, 100, 48, 1'b0);
      cfg_one(1, 3, 100, 300, 1'b0);
      cfg_one(2, 1, 100, 21, 1'b1);
      build_expected(40);
      bus.en_low_i = 1'b0;
      repeat (12) tick();
      #1 rst = 1'b0;
      #1;
      chk("async_rst_wr_en", int'(bus.wr_en_o), 0);
      chk("async_rst_data", int'(bus.data_o), 0);
      chk("async_rst_ch", int'(bus.ch_o), 0);
      chk("async_rst_state", int'(bus.state_o), 0);
      exp_q.delete();
      model_reset();
      bus.en_low_i = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      run_burst(30, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
